pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter and instruction-fetch sequencer; consumes the branch unit's branch/offset_out pair.
//  Holds PC and issues word fetches to instruction memory over a req/rdy handshake.
//  Redirects on taken branch/call/return, squashing wrong-path fetches; returns the link address for calls.
// PARAMETERS
//  PC_W      32  PC / instruction-address width (word addressing, PC steps by 1)
//  OFF_W     26  branch offset/target width
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  clk         in   1      clock
//  rst         in   1      reset, synchronous active-high
//  stall       in   1      downstream hold: no new fetch is issued while high
//  branch      in   1      taken redirect this cycle (branch unit output)
//  offset      in   OFF_W  redirect offset/target (branch unit offset_out)
//  abs_tgt     in   1      1: offset is absolute target (branch-to-register, return); 0: PC-relative
//  is_call     in   1      redirect is a call; qualifies link write
//  br_pc       in   PC_W   PC of the redirecting instruction
//  imem_req    out  1      fetch request
//  imem_addr   out  PC_W   fetch address, stable while imem_req high and imem_rdy low
//  imem_rdy    in   1      memory accepts and returns the word this cycle
//  instr_valid out  1      one-cycle pulse: fetched word is on the right path
//  instr_pc    out  PC_W   PC of the word flagged by instr_valid
//  link_we     out  1      one-cycle pulse: write link_pc to the return-address register
//  link_pc     out  PC_W   br_pc+1 of the call
// BEHAVIOUR
//  Reset (rst sampled at posedge): pc=RESET_PC, state=FETCH, imem_req=0, instr_valid=0, link_we=0,
//   instr_pc=0, link_pc=0. The first request is issued the cycle after rst drops. Reset mid-fetch drops that fetch.
//  Target: abs_tgt ? zero-extend(offset) : br_pc + 1 + sign-extend(offset); sum modulo 2^PC_W (wraps).
//  States:
//   FETCH: imem_req = !stall || outstanding; imem_addr = fetch-address register.
//    Once a request is raised, it stays raised with a frozen address until imem_rdy, even if stall rises.
//    imem_rdy&req -> instr_valid=1 and instr_pc=fetch address, next cycle; pc<=pc+1.
//   DRAIN: entered on a redirect while a request is outstanding and imem_rdy=0.
//    imem_req stays high with the old address until imem_rdy; the returned word is discarded (no instr_valid).
//    Then go to FETCH at the redirect target.
//  Redirect (branch=1) in cycle t:
//   - pc<=target.
//   - Any word completing in cycle t is squashed: instr_valid=0 at t+1.
//   - If no request is outstanding, or imem_rdy=1 at t: next request at t+1 uses the target (FETCH).
//   - Otherwise go to DRAIN.
//   - A second redirect while in DRAIN overwrites the pending target (latest wins).
//  Link: branch&is_call at t -> link_we=1 and link_pc=br_pc+1 at t+1; no link on squash-only paths.
//  Simultaneous stall&branch: the redirect is taken; the fetch of the target waits for !stall.
//  Fetch latency: 1 cycle minimum (req at t, rdy at t -> instr_valid at t+1); wait states extend it.
//  No combinational path from imem_rdy to imem_req or imem_addr.
// STRUCTURE
//  Shared package/header: PC_W, OFF_W, RESET_PC, state encodings (S_FETCH, S_DRAIN).
//  One natural sub-module: pc_target_calc, the combinational target adder/mux; the rest is a flat FSM
//   with pc, fetch-address, pending-target and output registers.
// TESTING
//  1. Reset, imem_rdy tied 1, no branch -> imem_addr 0,1,2,3 on successive cycles; instr_pc 0,1,2 one cycle later.
//  2. br_pc=5, offset=26'h3FFFFFE, abs_tgt=0, branch pulse -> next fetch addr 4 (5+1-2); the sequential word is squashed.
//  3. abs_tgt=1, offset=26'h40, is_call=1, br_pc=9 -> next fetch addr 0x40; link_we pulse with link_pc=10.
//  4. imem_rdy held 0 for 3 cycles with addr 7 outstanding, branch to 0x20 mid-wait
//     -> addr 7 held, returned word dropped, then fetch addr 0x20.
//  5. stall high 4 cycles with rdy=1 -> imem_req low after the in-flight word; resume at the next sequential PC.
//  6. rst asserted during DRAIN -> next cycle all outputs at reset values; first fetch addr RESET_PC.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared widths, reset PC and FSM state encoding for the PC/fetch sequencer.
package pc_sequencer_pkg;

   localparam int unsigned PC_W  = 32;
   localparam int unsigned OFF_W = 26;

   localparam logic [PC_W-1:0] RESET_PC = '0;

   typedef enum logic {
      S_FETCH = 1'b0,
      S_DRAIN = 1'b1
   } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer and instruction memory.
interface pc_sequencer_if;
   import pc_sequencer_pkg::*;

   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_rdy;

   modport master (output imem_req, output imem_addr, input imem_rdy);
   modport slave  (input imem_req, input imem_addr, output imem_rdy);

endinterface

// File: rtl/pc_target_calc.sv
// Redirect target: absolute zero-extended offset, or br_pc + 1 + sign-extended offset (wrapping).
module pc_target_calc
   import pc_sequencer_pkg::*;
(
   input  logic [OFF_W-1:0] offset,
   input  logic             abs_tgt,
   input  logic [PC_W-1:0]  br_pc,
   output logic [PC_W-1:0]  target_c
);

   localparam int unsigned EXT_W = PC_W - OFF_W;

   logic [PC_W-1:0] off_zx;
   logic [PC_W-1:0] off_sx;

   // Extend the offset both ways and select the redirect target.
   always_comb begin
      off_zx   = {{EXT_W{1'b0}}, offset};
      off_sx   = {{EXT_W{offset[OFF_W-1]}}, offset};
      target_c = abs_tgt ? off_zx : (br_pc + PC_W'(1) + off_sx);
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter and instruction-fetch sequencer with redirect squash and call link output.
// pc doubles as the fetch address; while draining a wrong-path request the redirect target
// waits in pend so the held address stays stable until memory accepts it.
module pc_sequencer
   import pc_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             branch,
   input  logic [OFF_W-1:0] offset,
   input  logic             abs_tgt,
   input  logic             is_call,
   input  logic [PC_W-1:0]  br_pc,
   pc_sequencer_if.master   imem,
   output logic             instr_valid,
   output logic [PC_W-1:0]  instr_pc,
   output logic             link_we,
   output logic [PC_W-1:0]  link_pc
);

   state_e          state;
   state_e          state_nxt;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pend;
   logic            outst;
   logic            req_c;
   logic            fire_c;
   logic [PC_W-1:0] target_c;

   pc_target_calc u_target (
      .offset   (offset),
      .abs_tgt  (abs_tgt),
      .br_pc    (br_pc),
      .target_c (target_c)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_nxt;
   end

   // Next state: drain when redirected with an unaccepted request; leave drain on acceptance.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_FETCH: if (branch && req_c && !imem.imem_rdy) state_nxt = S_DRAIN;
         S_DRAIN: if (imem.imem_rdy)                     state_nxt = S_FETCH;
         default: state_nxt = S_FETCH;
      endcase
   end

   // Fetch request: a raised request holds until accepted; new requests wait for !stall.
   always_comb begin
      req_c = 1'b0;
      unique case (state)
         S_FETCH: req_c = outst || !stall;
         S_DRAIN: req_c = 1'b1;
         default: req_c = 1'b0;
      endcase
      if (rst) req_c = 1'b0;
   end

   assign fire_c         = req_c && imem.imem_rdy;
   assign imem.imem_req  = req_c;
   assign imem.imem_addr = pc;

   // PC, pending target, outstanding flag and registered instruction/link outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         pend        <= RESET_PC;
         outst       <= 1'b0;
         instr_valid <= 1'b0;
         instr_pc    <= '0;
         link_we     <= 1'b0;
         link_pc     <= '0;
      end else begin
         instr_valid <= 1'b0;
         link_we     <= branch && is_call;
         if (branch && is_call) link_pc <= br_pc + PC_W'(1);
         unique case (state)
            S_FETCH: begin
               if (branch) begin
                  if (req_c && !imem.imem_rdy) begin
                     pend  <= target_c;
                     outst <= 1'b1;
                  end else begin
                     pc    <= target_c;
                     outst <= 1'b0;
                  end
               end else if (fire_c) begin
                  instr_valid <= 1'b1;
                  instr_pc    <= pc;
                  pc          <= pc + PC_W'(1);
                  outst       <= 1'b0;
               end else begin
                  outst <= req_c;
               end
            end
            S_DRAIN: begin
               if (imem.imem_rdy) begin
                  pc    <= branch ? target_c : pend;
                  outst <= 1'b0;
               end else if (branch) begin
                  pend <= target_c;
               end
            end
            default: outst <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios plus randomized traffic against a
// transaction-level fetch model; a separate monitor pops expected instr/link results.
module tb_pc_sequencer;
   import pc_sequencer_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             stall = 1'b0;
   logic             branch = 1'b0;
   logic [OFF_W-1:0] offset = '0;
   logic             abs_tgt = 1'b0;
   logic             is_call = 1'b0;
   logic [PC_W-1:0]  br_pc = '0;
   logic             instr_valid;
   logic [PC_W-1:0]  instr_pc;
   logic             link_we;
   logic [PC_W-1:0]  link_pc;

   pc_sequencer_if imem ();
   initial imem.imem_rdy = 1'b0;

   pc_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .branch      (branch),
      .offset      (offset),
      .abs_tgt     (abs_tgt),
      .is_call     (is_call),
      .br_pc       (br_pc),
      .imem        (imem),
      .instr_valid (instr_valid),
      .instr_pc    (instr_pc),
      .link_we     (link_we),
      .link_pc     (link_pc)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [31:0] exp_instr_q[$];
   logic [31:0] exp_link_q[$];

   // Model state: next architectural fetch address and the currently raised request.
   logic [31:0] m_fetch = 32'd0;
   logic        m_busy = 1'b0;
   logic [31:0] m_busy_addr = 32'd0;
   logic        m_doomed = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_target(input logic [25:0] off, input logic abs,
                                                input logic [31:0] bpc);
      longint so;
      if (abs) return 32'(longint'(off));
      so = longint'(off);
      if (off[25]) so = so - 64'sd67108864;
      return 32'(longint'(bpc) + 64'sd1 + so);
   endfunction

   // One clock cycle: drive at negedge, check request bus, advance the model.
   task automatic cyc(input logic r, input logic s, input logic b, input logic [25:0] off,
                      input logic abs, input logic call, input logic [31:0] bpc,
                      input logic rdy);
      logic        req_e;
      logic [31:0] addr_e;
      logic [31:0] tgt;
      @(negedge clk);
      rst = r; stall = s; branch = b; offset = off; abs_tgt = abs;
      is_call = call; br_pc = bpc; imem.imem_rdy = rdy;
      #1;
      if (r) begin
         chk("req_in_reset", 32'(imem.imem_req), 32'd0);
         m_fetch = 32'(RESET_PC); m_busy = 1'b0; m_doomed = 1'b0;
      end else begin
         req_e  = m_busy || !s;
         addr_e = m_busy ? m_busy_addr : m_fetch;
         chk("imem_req", 32'(imem.imem_req), 32'(req_e));
         if (req_e) chk("imem_addr", imem.imem_addr, addr_e);
         if (b) begin
            tgt = model_target(off, abs, bpc);
            if (call) exp_link_q.push_back(bpc + 32'd1);
            if (req_e && !rdy) begin
               m_busy = 1'b1; m_busy_addr = addr_e; m_doomed = 1'b1;
            end else begin
               m_busy = 1'b0; m_doomed = 1'b0;
            end
            m_fetch = tgt;
         end else if (req_e && rdy) begin
            if (!m_doomed) begin
               exp_instr_q.push_back(addr_e);
               m_fetch = addr_e + 32'd1;
            end
            m_busy = 1'b0; m_doomed = 1'b0;
         end else if (req_e) begin
            m_busy = 1'b1; m_busy_addr = addr_e;
         end
      end
   endtask

   task automatic run(input logic s, input logic rdy);
      cyc(1'b0, s, 1'b0, 26'd0, 1'b0, 1'b0, 32'd0, rdy);
   endtask

   // Monitor: compare every presented instruction and link pulse against the scoreboard.
   initial begin
      logic [31:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (instr_valid) begin
            if (exp_instr_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL instr_unexpected actual=%h required=none t=%0t", instr_pc, $time);
            end else begin
               e = exp_instr_q.pop_front();
               chk("instr_pc", instr_pc, e);
            end
         end
         if (link_we) begin
            if (exp_link_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL link_unexpected actual=%h required=none t=%0t", link_pc, $time);
            end else begin
               e = exp_link_q.pop_front();
               chk("link_pc", link_pc, e);
            end
         end
      end
   end

   initial begin
      // Reset and sequential fetch with memory always ready.
      cyc(1'b1, 1'b0, 1'b0, 26'd0, 1'b0, 1'b0, 32'd0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 26'd0, 1'b0, 1'b0, 32'd0, 1'b1);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_link_we", 32'(link_we), 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_link_pc", link_pc, 32'd0);
      for (int i = 0; i < 4; i++) begin
         run(1'b0, 1'b1);
         chk("t1_addr", imem.imem_addr, 32'(i));
      end

      // Relative backward branch squashes the sequential word.
      cyc(1'b0, 1'b0, 1'b1, 26'h3FFFFFE, 1'b0, 1'b0, 32'd5, 1'b1);
      run(1'b0, 1'b1);
      chk("t2_addr", imem.imem_addr, 32'd4);

      // Absolute call with link write.
      cyc(1'b0, 1'b0, 1'b1, 26'h40, 1'b1, 1'b1, 32'd9, 1'b1);
      run(1'b0, 1'b1);
      chk("t3_addr", imem.imem_addr, 32'h40);
      chk("t3_link_we", 32'(link_we), 32'd1);
      chk("t3_link_pc", link_pc, 32'd10);
      run(1'b0, 1'b1);
      run(1'b0, 1'b1);

      // Stall for four cycles, then resume sequentially.
      for (int i = 0; i < 4; i++) begin
         run(1'b1, 1'b1);
         chk("t5_req_low", 32'(imem.imem_req), 32'd0);
      end
      run(1'b0, 1'b1);
      chk("t5_resume", imem.imem_addr, 32'h43);

      // Redirect during wait states: addr 7 held, word dropped, then target.
      cyc(1'b1, 1'b0, 1'b0, 26'd0, 1'b0, 1'b0, 32'd0, 1'b1);
      for (int i = 0; i < 7; i++) run(1'b0, 1'b1);
      run(1'b0, 1'b0);
      chk("t4_hold0", imem.imem_addr, 32'd7);
      cyc(1'b0, 1'b1, 1'b1, 26'h20, 1'b1, 1'b0, 32'd0, 1'b0);
      chk("t4_hold1", imem.imem_addr, 32'd7);
      run(1'b1, 1'b0);
      chk("t4_drain_req", 32'(imem.imem_req), 32'd1);
      run(1'b0, 1'b1);
      chk("t4_drain_addr", imem.imem_addr, 32'd7);
      run(1'b0, 1'b1);
      chk("t4_target", imem.imem_addr, 32'h20);

      // Reset while draining.
      run(1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 26'h100, 1'b1, 1'b1, 32'h55, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 26'd0, 1'b0, 1'b0, 32'd0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 26'd0, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("t6_instr_valid", 32'(instr_valid), 32'd0);
      chk("t6_link_we", 32'(link_we), 32'd0);
      chk("t6_instr_pc", instr_pc, 32'd0);
      chk("t6_link_pc", link_pc, 32'd0);
      run(1'b0, 1'b1);
      chk("t6_first_addr", imem.imem_addr, 32'(RESET_PC));

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         cyc(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 9) == 0),
             26'($urandom),
             1'($urandom),
             1'($urandom),
             $urandom,
             ($urandom_range(0, 9) < 6));
      end

      // Let outstanding work complete, then everything expected must have been seen.
      for (int i = 0; i < 4; i++) run(1'b1, 1'b1);
      @(posedge clk);
      #2;
      chk("instr_q_empty", 32'(exp_instr_q.size()), 32'd0);
      chk("link_q_empty", 32'(exp_link_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
